// File: rtl/pattern_sequencer_if.sv
// Control/table-write and pattern-output bundle for pattern_sequencer.
// The master side drives the controls and writes; the slave side (the sequencer) drives the pattern outputs.
interface pattern_sequencer_if #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 8
);
  localparam int AW = $clog2(DEPTH);

  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic [DWELL_W-1:0] wr_dwell;
  logic [AW:0]        len;
  logic               loop;
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   pat_out;
  logic               pat_valid;
  logic [AW-1:0]      idx;
  logic               busy;
  logic               done;

  modport master (
    output wr_en, wr_addr, wr_data, wr_dwell, len, loop, start, abort,
    input  pat_out, pat_valid, idx, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_dwell, len, loop, start, abort,
    output pat_out, pat_valid, idx, busy, done
  );
endinterface

// File: rtl/pattern_sequencer.sv
// Plays a table of patterns, each held for dwell+1 cycles; the first entry appears one cycle after start.
// No backpressure: output is free-running while busy, and the table is write-locked during playback.
module pattern_sequencer #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 8,
  parameter int DWELL_W    = 8,
  parameter int IDLE_VALUE = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  pattern_sequencer_if.slave  io_seq
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      LEN_MAX  = (AW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] IDLE_PAT = WIDTH'(IDLE_VALUE);

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_pat_mem   [DEPTH];
  logic [DWELL_W-1:0] r_dwell_mem [DEPTH];
  logic [WIDTH-1:0]   r_pat;
  logic [AW-1:0]      r_idx;
  logic [DWELL_W-1:0] r_cnt;
  logic [AW:0]        r_len;
  logic               r_loop;
  logic               r_done;

  logic               w_start;
  logic               w_cnt_zero;
  logic               w_last;
  logic [AW:0]        w_len_clamp;
  logic [AW-1:0]      w_idx_nxt;

  assign w_start     = io_seq.start && !io_seq.abort && (io_seq.len != '0);
  assign w_len_clamp = (io_seq.len > LEN_MAX) ? LEN_MAX : io_seq.len;
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_last      = ({1'b0, r_idx} == (r_len - 1'b1));
  assign w_idx_nxt   = w_last ? '0 : (r_idx + 1'b1);

  always_ff @(posedge i_clk) begin
    if (io_seq.wr_en && (r_state == S_IDLE)) begin
      r_pat_mem[io_seq.wr_addr]   <= io_seq.wr_data;
      r_dwell_mem[io_seq.wr_addr] <= io_seq.wr_dwell;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_PLAY;
      S_PLAY:  if (io_seq.abort || (w_cnt_zero && w_last && !r_loop)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Abort freezes pattern and index in place; only the FSM leaves PLAY.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pat  <= IDLE_PAT;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_len  <= '0;
      r_loop <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_start) begin
          r_idx  <= '0;
          r_pat  <= r_pat_mem[0];
          r_cnt  <= r_dwell_mem[0];
          r_len  <= w_len_clamp;
          r_loop <= io_seq.loop;
        end
      end else if (!io_seq.abort) begin
        if (!w_cnt_zero) begin
          r_cnt <= r_cnt - 1'b1;
        end else if (!w_last || r_loop) begin
          r_idx <= w_idx_nxt;
          r_pat <= r_pat_mem[w_idx_nxt];
          r_cnt <= r_dwell_mem[w_idx_nxt];
        end else begin
          r_done <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    io_seq.pat_out   = r_pat;
    io_seq.idx       = r_idx;
    io_seq.busy      = (r_state == S_PLAY);
    io_seq.pat_valid = (r_state == S_PLAY);
    io_seq.done      = r_done;
  end
endmodule
